switch_drain: RTL



---
 rtl/switch_drain_pkg.sv | 18 +
 rtl/rr_grant4.sv | 27 ++
 rtl/switch_drain.sv | 108 ++++++++++
 3 files changed

// File: rtl/switch_drain_pkg.sv
// switch_drain_pkg: shared constants, state encoding and route-field helper for the egress drain reader
package switch_drain_pkg;

    localparam int PORT_W    = 2;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // The destination port field occupies the top PORT_W bits of a word
    function automatic int route_lsb(input int dw);
        return dw - PORT_W;
    endfunction

endpackage

// File: rtl/rr_grant4.sv
// rr_grant4: combinational 4-way round-robin arbiter, one-hot grant plus next pointer
module rr_grant4
    import switch_drain_pkg::*;
(
    input  logic [3:0]        req,
    input  logic [PORT_W-1:0] ptr,
    output logic [3:0]        gnt,
    output logic [PORT_W-1:0] next_ptr
);

    logic [PORT_W-1:0] idx;

    // Scan from lowest to highest priority so the requester nearest ptr is the last writer
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        idx      = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + PORT_W'(i);
            if (req[idx]) begin
                gnt      = 4'b0001 << idx;
                next_ptr = idx + PORT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_drain.sv
// switch_drain: round-robin egress reader for the switch output FIFOs with a 2-entry valid/ready queue
module switch_drain
    import switch_drain_pkg::*;
#(
    parameter int data_width = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            empty_fifos,
    input  logic [data_width-1:0] FIFO_data_out4,
    input  logic [data_width-1:0] FIFO_data_out5,
    input  logic [data_width-1:0] FIFO_data_out6,
    input  logic [data_width-1:0] FIFO_data_out7,
    output logic                  pop4,
    output logic                  pop5,
    output logic                  pop6,
    output logic                  pop7,
    output logic [data_width-1:0] data_out,
    output logic [PORT_W-1:0]     port_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  idle_out,
    output logic                  route_err,
    output logic [7:0]            word_count
);

    localparam int RL = route_lsb(data_width);

    state_t                state, nstate;
    logic [PORT_W-1:0]     ptr, next_ptr, gidx, inf_port;
    logic [3:0]            req, gnt, pop;
    logic                  inflight, can_pop, deq, drained, rd_ptr, wr_ptr, unused_flags;
    logic [1:0]            occ;
    logic [data_width-1:0] rd_word;
    logic [data_width-1:0] q_data [BUF_DEPTH];
    logic [PORT_W-1:0]     q_port [BUF_DEPTH];

    assign unused_flags = ^empty_fifos[3:0];
    assign req          = ~empty_fifos[7:4];
    assign deq          = valid_out && ready_in;
    assign drained      = occ == 2'd0 && !inflight;
    // A head word leaving this cycle frees its slot, which is what lets pops sustain one per cycle
    assign can_pop      = enable && !reset && |req && (int'(occ) + int'(inflight) - int'(deq) < BUF_DEPTH);
    assign gidx         = next_ptr - PORT_W'(1);
    assign pop          = can_pop ? gnt : 4'b0000;
    assign {pop7, pop6, pop5, pop4} = pop;
    assign rd_word      = inf_port == 2'd0 ? FIFO_data_out4 :
                          inf_port == 2'd1 ? FIFO_data_out5 :
                          inf_port == 2'd2 ? FIFO_data_out6 : FIFO_data_out7;
    assign valid_out    = occ != 2'd0;
    assign data_out     = q_data[rd_ptr];
    assign port_out     = q_port[rd_ptr];

    rr_grant4 u_rr (
        .req      (req),
        .ptr      (ptr),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    // Next FSM state: leaving DRAIN prefers re-activation over going idle
    always_comb
        nstate = state == IDLE   ? (enable && |req ? ACTIVE : IDLE) :
                 state == ACTIVE ? (!enable ? DRAIN : (!(|req) && drained ? IDLE : ACTIVE)) :
                 (enable ? ACTIVE : (drained ? IDLE : DRAIN));

    // Arbitration pointer, inflight read, output queue, status counters and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            inflight   <= 1'b0;
            inf_port   <= '0;
            occ        <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            q_data     <= '{default: '0};
            q_port     <= '{default: '0};
            route_err  <= 1'b0;
            word_count <= '0;
            state      <= IDLE;
            idle_out   <= 1'b1;
        end else begin
            if (can_pop)
                ptr <= next_ptr;
            inflight <= can_pop;
            inf_port <= gidx;
            if (inflight) begin
                q_data[wr_ptr] <= rd_word;
                q_port[wr_ptr] <= inf_port;
                wr_ptr         <= ~wr_ptr;
                if (rd_word[RL +: PORT_W] != inf_port)
                    route_err <= 1'b1;
            end
            if (deq) begin
                rd_ptr     <= ~rd_ptr;
                word_count <= word_count + 8'd1;
            end
            occ      <= occ + {1'b0, inflight} - {1'b0, deq};
            state    <= nstate;
            idle_out <= nstate == IDLE;
        end
    end

    ovf_chk: assert property (@(posedge clk) disable iff (reset)
        !(inflight && occ == 2'(BUF_DEPTH) && !deq) && occ <= 2'(BUF_DEPTH));

endmodule
